// File: rtl/alu_bist_sequencer.sv
// alu_bist_sequencer: run-time controller for the ALU built-in self-test
// Ports:
//   clk, reset (sync, active-low)  clock and reset
//   start, abort                  run control from test-mode logic
//   op_mask                       per-opcode exclusion from failure accounting
//   match                         comparator result for the current vector
//   alu_sel, rom_addr             current vector {pat_idx, alu_sel}
//   pg_clr, pg_en                 pattern-generator clear / advance
//   busy, done, pass              run status
//   fail_cnt, first_fail_*        failure count and first failing address
module alu_bist_sequencer #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        op_mask,
    input  logic               match,
    output logic [3:0]         alu_sel,
    output logic [PAT_W+3:0]   rom_addr,
    output logic               pg_clr,
    output logic               pg_en,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [PAT_W+3:0]   first_fail_addr,
    output logic               first_fail_vld
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
    state_t state, state_n;
    logic [PAT_W-1:0] pat_idx, pat_n;
    logic [3:0] op_idx, op_n;
    logic [CNT_W-1:0] cnt_n;
    logic [PAT_W+3:0] ffa_n;
    logic ffv_n, fail, last;
    assign alu_sel  = op_idx;
    assign rom_addr = {pat_idx, op_idx};
    always_comb begin
        state_n = state;
        pat_n   = pat_idx;
        op_n    = op_idx;
        cnt_n   = fail_cnt;
        ffa_n   = first_fail_addr;
        ffv_n   = first_fail_vld;
        fail    = state == RUN && !match && !op_mask[op_idx];
        last    = &pat_idx && &op_idx;
        if (abort || (start && (state == IDLE || state == DONE))) begin
            state_n = abort ? IDLE : INIT;
            pat_n   = '0;
            op_n    = '0;
            cnt_n   = '0;
            ffa_n   = '0;
            ffv_n   = 1'b0;
        end else if (state == INIT) begin
            state_n = RUN;
        end else if (state == RUN) begin
            state_n = last ? DONE : RUN;
            op_n    = op_idx + 4'd1;
            pat_n   = &op_idx ? pat_idx + PAT_W'(1) : pat_idx;
            if (fail) begin
                cnt_n = &fail_cnt ? fail_cnt : fail_cnt + CNT_W'(1);
                ffa_n = first_fail_vld ? first_fail_addr : rom_addr;
                ffv_n = 1'b1;
            end
        end
    end
    // Outputs are registered from next-state values so pg_en is high during
    // the op 15 cycle and the generators step on the same edge as pat_idx.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            pat_idx         <= '0;
            op_idx          <= '0;
            fail_cnt        <= '0;
            first_fail_addr <= '0;
            first_fail_vld  <= 1'b0;
            pg_clr          <= 1'b0;
            pg_en           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            state           <= state_n;
            pat_idx         <= pat_n;
            op_idx          <= op_n;
            fail_cnt        <= cnt_n;
            first_fail_addr <= ffa_n;
            first_fail_vld  <= ffv_n;
            pg_clr          <= state_n == INIT;
            pg_en           <= state_n == RUN && &op_n && !(&pat_n);
            busy            <= state_n == INIT || state_n == RUN;
            done            <= state_n == DONE;
            pass            <= state_n == DONE && cnt_n == '0;
        end
    end
endmodule

// File: tb/tb_alu_bist_sequencer.sv
// tb_alu_bist_sequencer: randomized self-checking bench for alu_bist_sequencer
module tb_alu_bist_sequencer;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, match;
    logic [15:0] op_mask = '0;
    logic [3:0] alu_sel, s_alu_sel;
    logic [7:0] rom_addr, s_rom_addr, first_fail_addr, s_ffa;
    logic pg_clr, pg_en, busy, done, pass, first_fail_vld;
    logic s_pg_clr, s_pg_en, s_busy, s_done, s_pass, s_ffv;
    logic [8:0] fail_cnt;
    logic [3:0] s_fail_cnt;
    logic bad [0:255];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign match = !bad[rom_addr];

    alu_bist_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op_mask(op_mask),
        .match(match), .alu_sel(alu_sel), .rom_addr(rom_addr), .pg_clr(pg_clr),
        .pg_en(pg_en), .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .first_fail_addr(first_fail_addr), .first_fail_vld(first_fail_vld)
    );

    alu_bist_sequencer #(.PAT_W(4), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op_mask(op_mask),
        .match(match), .alu_sel(s_alu_sel), .rom_addr(s_rom_addr), .pg_clr(s_pg_clr),
        .pg_en(s_pg_en), .busy(s_busy), .done(s_done), .pass(s_pass), .fail_cnt(s_fail_cnt),
        .first_fail_addr(s_ffa), .first_fail_vld(s_ffv)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {alu_sel, rom_addr, pg_clr, pg_en, busy, done, pass, fail_cnt,
                first_fail_addr, first_fail_vld};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full run: expected results come from scanning the fault map in vector order.
    task automatic run_full(input string tag, input logic [15:0] m);
        int n, first, seq_bad, pgen, pclr, lat;
        n = 0;
        first = 0;
        for (int a = 0; a < 256; a++)
            if (bad[a] && !m[a % 16]) begin
                if (n == 0) first = a;
                n++;
            end
        op_mask = m;
        pulse_start();
        chk({tag, "_init_busy"}, busy, 1);
        pclr = int'(pg_clr);
        seq_bad = 0;
        pgen = 0;
        lat = 0;
        for (int j = 1; j <= 300; j++) begin
            step();
            if (done) begin
                lat = j + 1;
                break;
            end
            pclr += int'(pg_clr);
            pgen += int'(pg_en);
            if (alu_sel != 4'((j - 1) % 16) || rom_addr != 8'(j - 1) || !busy ||
                pg_en != ((j - 1) % 16 == 15 && j - 1 < 255))
                seq_bad++;
        end
        chk({tag, "_latency"}, lat, 258);
        chk({tag, "_seq"}, seq_bad, 0);
        chk({tag, "_pg_clr_cnt"}, pclr, 1);
        chk({tag, "_pg_en_cnt"}, pgen, 15);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_fail_cnt"}, fail_cnt, n > 511 ? 511 : n);
        chk({tag, "_sat_cnt"}, s_fail_cnt, n > 15 ? 15 : n);
        chk({tag, "_pass"}, pass, n == 0);
        chk({tag, "_sat_pass"}, s_pass, n == 0);
        chk({tag, "_ffv"}, first_fail_vld, n > 0);
        chk({tag, "_ffa"}, first_fail_addr, first);
        repeat (5) step();
        chk({tag, "_hold"}, {done, fail_cnt, first_fail_addr}, {1'b1, 9'(n), 8'(first)});
    endtask

    initial begin
        for (int a = 0; a < 256; a++) bad[a] = 1'b0;
        repeat (2) step();
        chk("reset_outs", all_outs(), 0);
        chk("reset_sat_busy", s_busy, 0);
        reset = 1'b1;
        repeat (50) step();
        chk("idle_hold", all_outs(), 0);

        run_full("clean", 16'h0000);
        bad[8'h23] = 1'b1;
        bad[8'h57] = 1'b1;
        run_full("two", 16'h0000);
        run_full("two_mask3", 16'h0008);
        for (int a = 0; a < 256; a++) bad[a] = 1'b1;
        run_full("all_bad", 16'h0000);
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 256; a++) bad[a] = $urandom_range(7) == 0;
            run_full($sformatf("rnd%0d", r), 16'($urandom));
        end

        for (int a = 0; a < 256; a++) bad[a] = 1'b1;
        op_mask = '0;
        pulse_start();
        repeat (101) step();
        chk("pre_abort_cnt", fail_cnt, 100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outs", {busy, done, pass, fail_cnt, first_fail_vld}, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        chk("start_abort_idle", {busy, pg_clr}, 0);
        pulse_start();
        repeat (41) step();
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        step();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        chk("midrun_reset", all_outs(), 0);
        for (int a = 0; a < 256; a++) bad[a] = $urandom_range(3) == 0;
        run_full("post_reset", 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_bist_sequencer.md
Name: alu_bist_sequencer

Overview:
- Run-time controller for the ALU built-in self-test.
- Steps the ALU opcode (alu_sel) through all 16 operations for each pattern-generator state, advancing the A/B pattern generators only after each full opcode sweep.
- Drives the golden-ROM address in lockstep as {pattern_idx, op_idx} and samples the comparator's match.
- Accumulates a failure count, captures the first failing vector and reports pass/fail; sits between the test-mode/JTAG control logic and the pattern-generator/ALU/ROM/comparator datapath.

Parameters:
- PAT_W, 4, log2 of the number of pattern states per run; the run covers 2^PAT_W pattern states x 16 opcodes.
- CNT_W, 9, failure counter width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- abort  in  1  cancel a run; forces IDLE on the next edge
- op_mask  in  16  bit k=1 excludes opcode k from failure accounting (the vector is still stepped)
- match  in  1  comparator result for the current alu_sel/rom_addr (combinational from this block's registered outputs)
- alu_sel  out  4  opcode presented to the ALU
- rom_addr  out  PAT_W+4  golden ROM address = {pat_idx, alu_sel}
- pg_clr  out  1  active-high clear to the pattern generators
- pg_en  out  1  advance the pattern generators by one state
- busy  out  1  high in INIT and RUN
- done  out  1  high in DONE
- pass  out  1  valid while done: 1 if fail_cnt==0
- fail_cnt  out  CNT_W  count of unmasked mismatches
- first_fail_addr  out  PAT_W+4  rom_addr of the first unmasked mismatch
- first_fail_vld  out  1  first_fail_addr holds a captured value

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-low; all state is updated only on the rising edge of clk.
- Reset (reset=0 at an edge): state=IDLE; alu_sel=0, rom_addr=0, pg_clr=0, pg_en=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_addr=0, first_fail_vld=0.
- All outputs are registered.
- IDLE:
  - Outputs are held.
  - start=1 -> INIT; on that edge fail_cnt, first_fail_vld, first_fail_addr, pat_idx and op_idx are cleared.
- INIT, exactly one cycle:
  - pg_clr=1, busy=1, alu_sel=0, rom_addr=0.
  - -> RUN.
- RUN: each cycle presents vector (pat_idx, op_idx).
  - match is sampled in the same cycle.
  - Failure accounting: if match=0 and op_mask[op_idx]=0, fail_cnt increments, saturating at all-ones. If first_fail_vld=0, first_fail_addr := rom_addr and first_fail_vld := 1.
  - op_idx increments every cycle.
  - When op_idx==15: op_idx wraps to 0, pg_en=1 for that cycle, and pat_idx increments on the same edge. The pattern generators update on that same edge, so the data stays aligned with the next rom_addr.
  - Last vector: pat_idx==2^PAT_W-1 and op_idx==15. After its compare -> DONE. pg_en stays 0 on this last vector.
  - RUN lasts exactly 16*2^PAT_W cycles (256 at default).
- DONE:
  - done=1, busy=0, pass=(fail_cnt==0).
  - Results hold until the next start, which behaves as from IDLE.
- Timing: start sampled at edge N -> INIT in cycle N+1 -> first RUN vector in cycle N+2 -> done=1 in cycle N+2+16*2^PAT_W.
- abort=1 in any state -> IDLE.
  - Counters, first_fail_* and done are cleared and pass=0.
  - abort has priority over start in the same cycle.
- start while busy is ignored.
- reset=0 mid-run overrides everything and gives the reset values above, regardless of abort/start.
- The failure counter never wraps. When fail_cnt is all-ones, further fails leave it unchanged and pass stays 0.
- op_mask is sampled every cycle; changing it mid-run affects only subsequent vectors.
- match is ignored outside RUN.

Test Plan:
- Reset with reset=0 for 2 cycles -> all outputs 0, state IDLE; release, no start -> outputs unchanged for 50 cycles.
- start pulse, match tied 1 -> pg_clr high exactly 1 cycle; alu_sel sequences 0..15 repeatedly; pg_en pulses 15 times, on op_idx==15 only; done=1 exactly 258 cycles after start is sampled; pass=1, fail_cnt=0, first_fail_vld=0.
- Full integration with the real ALU, pattern generators and ROM -> pass=1; inject a fault by forcing ALU_Out bit 0 stuck-at-0 for opcode 9 -> pass=0, fail_cnt>0, first_fail_addr[3:0]=9.
- match=0 only at rom_addr 0x23 and 0x57 -> fail_cnt=2, first_fail_addr=0x23; same run with op_mask[3]=1 -> fail_cnt=1, first_fail_addr=0x57.
- match tied 0 with CNT_W=4 -> fail_cnt saturates at 15 and holds, first_fail_addr=0x00, pass=0.
- abort at RUN cycle 100 -> IDLE next cycle, fail_cnt=0, done=0; start and abort in the same cycle -> stays IDLE; reset=0 at RUN cycle 40 -> reset values; start issued in DONE -> new run with counters cleared.
